// File: rtl/console_tx.sv
// Memory-mapped console transmitter: snoops CPU stores, queues the low byte of
// stores to the data register and shifts queued bytes out as 8N1 serial frames.
module console_tx #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_FFF0,
    parameter logic [31:0] CTRL_ADDR    = 32'h0000_FFF4,
    parameter int          DEPTH        = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_write,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    output logic                       tx,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    fifoMem [DEPTH];
    logic [PW-1:0] wrPtrReg;
    logic [PW-1:0] rdPtrReg;
    logic [CW-1:0] countReg;
    logic [CW-1:0] countNext;
    logic          overflowReg;

    logic [1:0]    stateReg;
    logic [1:0]    stateNext;
    logic [TW-1:0] timerReg;
    logic [TW-1:0] timerNext;
    logic [2:0]    bitIdxReg;
    logic [2:0]    bitIdxNext;
    logic [7:0]    shiftReg;
    logic [7:0]    shiftNext;
    logic          txReg;
    logic          txNext;

    logic          push;
    logic          ctrlWrite;
    logic          pop;
    logic          full;
    logic          fifoEmpty;
    logic          accept;
    logic          dropped;
    logic          timerEnd;
    logic [7:0]    headByte;
    logic          unusedWdata;

    assign unusedWdata = ^mem_wdata[31:8];

    assign push      = mem_write && (mem_addr == CONSOLE_ADDR);
    assign ctrlWrite = mem_write && (mem_addr == CTRL_ADDR);
    assign full      = (countReg == CW'(DEPTH));
    assign fifoEmpty = (countReg == '0);
    // A full FIFO still takes the byte when the head leaves on the same edge.
    assign accept    = push && (!full || pop);
    assign dropped   = push && full && !pop;
    assign timerEnd  = (timerReg == TW'(CLKS_PER_BIT - 1));
    assign headByte  = fifoMem[rdPtrReg];

    always_comb begin
        countNext = countReg;
        case ({accept, pop})
            2'b10:   countNext = countReg + CW'(1);
            2'b01:   countNext = countReg - CW'(1);
            default: countNext = countReg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifoMem[wrPtrReg] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
        end else begin
            countReg <= countNext;
            if (accept) begin
                wrPtrReg <= wrPtrReg + PW'(1);
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + PW'(1);
            end
            // Setting wins over a clear on the same edge.
            if (dropped) begin
                overflowReg <= 1'b1;
            end else if (ctrlWrite) begin
                overflowReg <= 1'b0;
            end
        end
    end

    always_comb begin
        stateNext  = stateReg;
        timerNext  = timerEnd ? '0 : timerReg + TW'(1);
        bitIdxNext = bitIdxReg;
        shiftNext  = shiftReg;
        txNext     = txReg;
        pop        = 1'b0;
        case (stateReg)
            IDLE: begin
                timerNext = '0;
                txNext    = 1'b1;
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shiftNext = headByte;
                    stateNext = START;
                    txNext    = 1'b0;
                end
            end
            START: begin
                if (timerEnd) begin
                    stateNext  = DATA;
                    bitIdxNext = 3'd0;
                    txNext     = shiftReg[0];
                end
            end
            DATA: begin
                if (timerEnd) begin
                    if (bitIdxReg == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        shiftNext  = shiftReg >> 1;
                        bitIdxNext = bitIdxReg + 3'd1;
                        txNext     = shiftReg[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next frame when bytes are waiting.
                if (timerEnd) begin
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        shiftNext = headByte;
                        stateNext = START;
                        txNext    = 1'b0;
                    end else begin
                        stateNext = IDLE;
                        txNext    = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                timerNext = '0;
                txNext    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            timerReg  <= '0;
            bitIdxReg <= '0;
            shiftReg  <= '0;
            txReg     <= 1'b1;
        end else begin
            stateReg  <= stateNext;
            timerReg  <= timerNext;
            bitIdxReg <= bitIdxNext;
            shiftReg  <= shiftNext;
            txReg     <= txNext;
        end
    end

    assign tx         = txReg;
    assign tx_busy    = (stateReg != IDLE);
    assign fifo_count = countReg;
    assign overflow   = overflowReg;

endmodule

// File: tb/tb_console_tx.sv
// Directed bench for console_tx: idle/reset state, single frame, burst with
// overflow, control clear, full-FIFO push on the pop edge and mid-frame reset.
module tb_console_tx;

    localparam int DEPTH = 8;
    localparam int CPB   = 16;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        tx;
    logic        tx_busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int checkCount = 0;
    int errorCount = 0;

    console_tx #(
        .CONSOLE_ADDR(32'h0000_FFF0),
        .CTRL_ADDR   (32'h0000_FFF4),
        .DEPTH       (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic expBit(input logic [7:0] b, input int c);
        if (c < CPB) return 1'b0;
        if (c >= 9 * CPB) return 1'b1;
        return b[(c - CPB) / CPB];
    endfunction

    // Caller sits on the negedge just before the edge that pops this byte.
    task automatic expectFrame(input logic [7:0] b);
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            checkVal("frame_tx", {31'd0, tx}, {31'd0, expBit(b, c)});
            checkVal("frame_busy", {31'd0, tx_busy}, 32'd1);
        end
        $display("frame %02h checked", b);
    endtask

    task automatic checkIdle(input string tag, input logic [3:0] cnt, input logic ovf);
        checkVal(tag, {28'd0, tx, tx_busy, overflow, 1'b0} | {28'd0, fifo_count},
                 {28'd0, 1'b1, 1'b0, ovf, 1'b0} | {28'd0, cnt});
    endtask

    task automatic storeWord(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        @(negedge clk);
        mem_write = 1'b0;
        $display("store addr %08h data %08h", addr, data);
    endtask

    initial begin
        reset     = 1'b1;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        #1;
        checkVal("reset_tx", {31'd0, tx}, 32'd1);
        checkVal("reset_busy", {31'd0, tx_busy}, 32'd0);
        checkVal("reset_count", {28'd0, fifo_count}, 32'd0);
        checkVal("reset_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle for 50 cycles
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkVal("idle_tx", {31'd0, tx}, 32'd1);
            checkVal("idle_busy", {31'd0, tx_busy}, 32'd0);
            checkVal("idle_count", {28'd0, fifo_count}, 32'd0);
            checkVal("idle_ovf", {31'd0, overflow}, 32'd0);
        end

        // Single store; upper data bits ignored
        storeWord(32'h0000_FFF0, 32'hDEAD_BE41);
        checkVal("single_count", {28'd0, fifo_count}, 32'd1);
        checkVal("single_pre_tx", {31'd0, tx}, 32'd1);
        checkVal("single_pre_busy", {31'd0, tx_busy}, 32'd0);
        expectFrame(8'h41);
        @(negedge clk);
        checkVal("single_end_busy", {31'd0, tx_busy}, 32'd0);
        checkVal("single_end_tx", {31'd0, tx}, 32'd1);
        checkVal("single_end_count", {28'd0, fifo_count}, 32'd0);

        // Burst of 10 consecutive stores, 0x39 dropped
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 32'h0000_FFF0;
        mem_wdata = 32'h30;
        fork
            begin
                for (int i = 1; i <= 9; i++) begin
                    @(negedge clk);
                    checkVal("burst_count", {28'd0, fifo_count}, (i == 1) ? 32'd1 : 32'(i - 1));
                    checkVal("burst_ovf", {31'd0, overflow}, 32'd0);
                    mem_wdata = 32'h30 + 32'(i);
                end
                @(negedge clk);
                mem_write = 1'b0;
                checkVal("burst_full_count", {28'd0, fifo_count}, 32'd8);
                checkVal("burst_ovf_set", {31'd0, overflow}, 32'd1);
            end
            begin
                @(negedge clk);
                for (int f = 0; f < 9; f++) begin
                    expectFrame(8'h30 + 8'(f));
                end
            end
        join
        @(negedge clk);
        checkVal("burst_end_busy", {31'd0, tx_busy}, 32'd0);
        checkVal("burst_end_ovf", {31'd0, overflow}, 32'd1);

        // Unmapped store changes nothing; control store clears overflow
        storeWord(32'h0000_FFF8, 32'h0000_0055);
        checkIdle("unmapped_state", 4'd0, 1'b1);
        repeat (3) @(negedge clk);
        checkIdle("unmapped_later", 4'd0, 1'b1);
        storeWord(32'h0000_FFF4, 32'h0000_0000);
        checkVal("ctrl_clear_ovf", {31'd0, overflow}, 32'd0);
        checkIdle("ctrl_clear_state", 4'd0, 1'b0);

        // Fill FIFO, then push exactly on the STOP->START pop edge
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 32'h0000_FFF0;
        mem_wdata = 32'h50;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            mem_wdata = 32'h50 + 32'(i);
        end
        @(negedge clk);
        mem_write = 1'b0;
        checkVal("fill_count", {28'd0, fifo_count}, 32'd8);
        checkVal("fill_ovf", {31'd0, overflow}, 32'd0);
        repeat (161 - 9) @(negedge clk);
        checkVal("popedge_pre_tx", {31'd0, tx}, 32'd1);
        checkVal("popedge_pre_count", {28'd0, fifo_count}, 32'd8);
        mem_write = 1'b1;
        mem_wdata = 32'h60;
        @(negedge clk);
        mem_write = 1'b0;
        checkVal("popedge_count", {28'd0, fifo_count}, 32'd8);
        checkVal("popedge_ovf", {31'd0, overflow}, 32'd0);
        checkVal("popedge_tx", {31'd0, tx}, 32'd0);
        checkVal("popedge_busy", {31'd0, tx_busy}, 32'd1);

        // Reset during DATA bit 3 of 0x51 (bit 3 = 0)
        repeat (70) @(negedge clk);
        checkVal("bit3_tx", {31'd0, tx}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        checkVal("midreset_tx", {31'd0, tx}, 32'd1);
        checkVal("midreset_busy", {31'd0, tx_busy}, 32'd0);
        checkVal("midreset_count", {28'd0, fifo_count}, 32'd0);
        checkVal("midreset_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkIdle("postreset_idle", 4'd0, 1'b0);
        end
        storeWord(32'h0000_FFF0, 32'h0000_00A5);
        checkVal("postreset_count", {28'd0, fifo_count}, 32'd1);
        expectFrame(8'hA5);
        @(negedge clk);
        checkIdle("postreset_end", 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/console_tx.md
Name: console_tx

Overview:
- Memory-mapped console output device that sits directly downstream of the pipeline's memory stage.
- It snoops the CPU store bus (address, write data, write enable).
- Stores to the console address have their low byte queued into a FIFO.
- A transmitter serializes queued bytes as 8N1 frames on a single output line, so syscall/stdout traffic leaves the core without stalling the pipeline.

Parameters:
- CONSOLE_ADDR, 32'h0000_FFF0, byte address of the data register; a store here enqueues wdata[7:0].
- CTRL_ADDR, 32'h0000_FFF4, byte address of the control register; any store here clears the sticky overflow flag.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 16, clock cycles per serial bit; at least 2.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- mem_write, input, 1, store strobe from the memory stage (MemWriteM).
- mem_addr, input, 32, store address (ALUOutM).
- mem_wdata, input, 32, store data (WriteDataM).
- tx, output, 1, serial line; idles high.
- tx_busy, output, 1, high whenever the FSM is not IDLE.
- fifo_count, output, $clog2(DEPTH)+1, number of queued bytes.
- overflow, output, 1, sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, tx_busy=0, fifo_count=0, overflow=0, FSM=IDLE.
  - Read/write pointers and the bit counter are zeroed.
  - Reset mid-frame aborts the frame; tx goes high immediately and FIFO contents are discarded.
- Push:
  - A push occurs on an edge where mem_write=1 and mem_addr==CONSOLE_ADDR (full 32-bit compare).
  - The byte pushed is mem_wdata[7:0]; mem_wdata[31:8] is ignored.
- Full/overflow:
  - full is evaluated from the pre-edge count, combined with that edge's pop.
  - If count==DEPTH and no pop on the same edge, the byte is dropped, overflow is set and count is unchanged.
  - If count==DEPTH and a pop occurs on the same edge, the push is accepted and count stays DEPTH.
- Control register:
  - A store with mem_addr==CTRL_ADDR clears overflow.
  - If an overflow set and a clear happen on the same edge, set wins.
- Non-matching stores are ignored. No bus read path exists; this block never drives read data.
- Count arithmetic:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0, pop the head byte into the shift register, go to START, reset the bit timer.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first), each bit for CLKS_PER_BIT cycles. Shift right after each bit; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- tx is a registered output: no glitches, changes only on clock edges (or on reset).
- Latency:
  - A push at edge k into an empty FIFO with the FSM in IDLE gives pop and START at edge k+1; tx falls after edge k+1.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
- Timer: a counter of width $clog2(CLKS_PER_BIT) runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- A push and an IDLE pop on the same edge with count==0 are not merged: the pop happens on the next edge (no bypass).

Test Plan:
- Reset then idle 50 cycles -> tx=1, tx_busy=0, fifo_count=0, overflow=0 throughout.
- Single store: addr 32'h0000_FFF0, wdata 32'hDEAD_BE41, CLKS_PER_BIT=16 -> tx low from edge k+1 for 16 cycles, then bits 1,0,0,0,0,0,1,0 (0x41, LSB first), then 16 high cycles; tx_busy high for exactly 160 cycles.
- Burst of 10 stores on consecutive cycles, bytes 0x30..0x39, DEPTH=8:
  - 0x30 is popped at the edge after its push.
  - 0x31..0x38 fill the FIFO and fifo_count reaches 8.
  - 0x39 is dropped and overflow=1.
  - Nine back-to-back frames follow with no idle gap.
- Store to CTRL_ADDR after the overflow -> overflow=0 on the next edge. A store to 32'h0000_FFF8 has no effect on any output.
- Full FIFO with a store on the exact STOP->START pop edge -> store accepted, fifo_count stays 8, overflow stays 0.
- Assert reset during DATA bit 3 -> tx=1 and tx_busy=0 immediately (before the next edge), fifo_count=0. After release, a new store transmits a clean, complete frame.
